// File: rtl/simon_pipeline_scheduler.sv
// Issue scheduler for a fully pipelined Simon 32/64 encrypt core: round-robin intake from
// two requesters, source/tag tracking through the core, and drained, settled key reloads.
module simon_pipeline_scheduler #(
  parameter int LATENCY    = 33,
  parameter int KEY_SETTLE = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  input  logic [63:0]      key_in,
  input  logic             key_update,
  output logic             key_busy,
  output logic [31:0]      core_plntxt,
  output logic             core_issue,
  output logic [63:0]      core_key,
  input  logic [31:0]      core_cphrtxt,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [5:0]       inflight,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_KEYLOAD = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;

  localparam int CNT_W = (KEY_SETTLE < 2) ? 1 : $clog2(KEY_SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(KEY_SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Control state
  logic [1:0]       state_q, state_d;
  logic [63:0]      pend_key_q, pend_key_d;
  logic [63:0]      core_key_q, core_key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic [5:0]       inflight_q, inflight_d;

  // Intake arbitration
  logic             run;
  logic             grant0, grant1;
  logic             accept;
  logic             acc_src;
  logic [31:0]      acc_data;
  logic [TAG_W-1:0] acc_tag;

  // Issue stage and tracker
  logic             issue_q;
  logic [31:0]      plntxt_q;
  logic             iss_src_q;
  logic [TAG_W-1:0] iss_tag_q;
  logic [LATENCY-1:0]            trk_v_q;
  logic [LATENCY-1:0]            trk_src_q;
  logic [LATENCY-1:0][TAG_W-1:0] trk_tag_q;
  logic             trk_exit;

  // Response register
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_src_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // valid/ready: a block transfers in a cycle where valid && ready. Ready is a combinational
  // function of both valids and the round-robin pointer, is only ever raised in RUN outside
  // reset, and at most one ready is high per cycle. A requester holds data/tag while valid.
  assign run    = (state_q == ST_RUN) && !rst;
  assign grant0 = run && req0_valid && (!req1_valid || !prio_q);
  assign grant1 = run && req1_valid && (!req0_valid ||  prio_q);
  assign accept = grant0 || grant1;
  assign acc_src  = grant1;
  assign acc_data = grant1 ? req1_data : req0_data;
  assign acc_tag  = grant1 ? req1_tag  : req0_tag;

  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = !acc_src;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !rsp_valid_q) begin
      inflight_d = inflight_q + 6'd1;
    end else if (!accept && rsp_valid_q) begin
      inflight_d = inflight_q - 6'd1;
    end
  end

  // Key sequencing: the schedule only changes once nothing is left in the core.
  always_comb begin
    state_d    = state_q;
    pend_key_d = pend_key_q;
    core_key_d = core_key_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (key_update) begin
          pend_key_d = key_in;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (key_update) pend_key_d = key_in;
        if (inflight_q == 6'd0) state_d = ST_KEYLOAD;
      end
      ST_KEYLOAD: begin
        // A pulse landing in this cycle is the newest key, so it is the one loaded.
        pend_key_d = key_update ? key_in : pend_key_q;
        core_key_d = key_update ? key_in : pend_key_q;
        cnt_d      = SETTLE_INIT;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (key_update) begin
          pend_key_d = key_in;
          state_d    = ST_DRAIN;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pend_key_q <= '0;
      core_key_q <= '0;
      cnt_q      <= '0;
      prio_q     <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_key_q <= pend_key_d;
      core_key_q <= core_key_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q   <= 1'b0;
      plntxt_q  <= '0;
      iss_src_q <= 1'b0;
      iss_tag_q <= '0;
    end else begin
      issue_q <= accept;
      if (accept) begin
        plntxt_q  <= acc_data;
        iss_src_q <= acc_src;
        iss_tag_q <= acc_tag;
      end
    end
  end

  // Tracker entries enter with the issue, so the last stage lines up with the core output.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_v_q   <= '0;
      trk_src_q <= '0;
      trk_tag_q <= '0;
    end else begin
      trk_v_q   <= {trk_v_q[LATENCY-2:0], issue_q};
      trk_src_q <= {trk_src_q[LATENCY-2:0], iss_src_q};
      trk_tag_q <= {trk_tag_q[LATENCY-2:0], iss_tag_q};
    end
  end

  assign trk_exit = trk_v_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_src_q   <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= trk_exit;
      if (trk_exit) begin
        rsp_data_q <= core_cphrtxt;
        rsp_src_q  <= trk_src_q[LATENCY-1];
        rsp_tag_q  <= trk_tag_q[LATENCY-1];
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign key_busy    = (state_q != ST_RUN);
  assign core_plntxt = plntxt_q;
  assign core_issue  = issue_q;
  assign core_key    = core_key_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_src     = rsp_src_q;
  assign rsp_tag     = rsp_tag_q;
  assign inflight    = inflight_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/simon_pipeline_scheduler.md
Name: simon_pipeline_scheduler

Overview:
- Sequencing and arbitration controller for the fully pipelined Simon 32/64 encrypt core.
- Accepts plaintext blocks from two requesters under valid/ready handshakes and grants between them round-robin, issuing at most one block per cycle into the core.
- Tracks each in-flight block's source and tag through the fixed pipeline latency and returns every ciphertext with that source and tag.
- Serialises key changes: the shared key schedule is only reloaded after the pipeline has fully drained and the new schedule has settled.

Parameters:
- LATENCY, 33: cycles from core_issue high to the matching result on core_cphrtxt; range 2..60.
- KEY_SETTLE, 2: cycles to wait after core_key changes before issuing again; must be ≥1.
- TAG_W, 4: width of the requester tag.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 block valid
- req0_data  in  32  requester 0 plaintext
- req0_tag  in  TAG_W  requester 0 tag
- req0_ready  out  1  requester 0 accept
- req1_valid  in  1  requester 1 block valid
- req1_data  in  32  requester 1 plaintext
- req1_tag  in  TAG_W  requester 1 tag
- req1_ready  out  1  requester 1 accept
- key_in  in  64  new key
- key_update  in  1  single-cycle pulse; captures key_in
- key_busy  out  1  key change in progress
- core_plntxt  out  32  plaintext to core
- core_issue  out  1  core_plntxt valid this cycle
- core_key  out  64  key to core key schedule
- core_cphrtxt  in  32  core ciphertext output
- rsp_valid  out  1  response valid, one cycle per block
- rsp_data  out  32  ciphertext
- rsp_src  out  1  originating requester
- rsp_tag  out  TAG_W  originating tag
- inflight  out  6  blocks accepted but not yet responded

Behaviour:
- Reset values: all outputs 0; state RUN; pending key 0; tracker valids cleared; round-robin pointer favours req0.
- Reset mid-operation discards all in-flight blocks. No rsp_valid may follow reset for pre-reset blocks.
- FSM states: RUN, DRAIN, KEYLOAD, SETTLE. key_busy = (state != RUN).
- RUN:
  - readyN = grant==N, where grant uses valids and the RR pointer.
  - If only one requester is valid, it is granted. If both are valid, the requester not granted last is granted.
  - The pointer updates only on an accept (valid && ready).
  - Ready may depend combinationally on valids.
- Accept at cycle t:
  - Cycle t+1: core_issue=1, core_plntxt=data.
  - A tracker shift register of LATENCY entries carries {valid, src, tag}. The entry exits in the cycle core_cphrtxt holds that block's result (t+1+LATENCY).
  - Cycle t+2+LATENCY: rsp_* is registered out, with rsp_data = core_cphrtxt sampled at exit.
  - rsp_valid is high exactly one cycle. There is no response backpressure.
- Ordering: responses emerge in accept order. Back-to-back accepts yield back-to-back responses.
- core_issue=0 in any cycle following no accept. core_plntxt holds its last value.
- inflight: +1 on accept, −1 on rsp_valid; unchanged when both occur in the same cycle.
- key_update in RUN:
  - Capture key_in into the pending key; next state DRAIN.
  - An accept in the same cycle still completes and uses the old key.
- DRAIN: readys 0. key_update overwrites the pending key. Go to KEYLOAD when inflight==0.
- KEYLOAD (1 cycle): core_key <= pending key; go to SETTLE with counter=KEY_SETTLE.
- SETTLE:
  - Counter decrements each cycle; go to RUN when it reaches 1.
  - key_update in SETTLE: capture the new key, return to DRAIN; this proceeds immediately to KEYLOAD since the pipeline is empty.
- key_update in DRAIN or KEYLOAD overwrites the pending key. The last captured key is the one loaded.
- The first key load also follows this flow. core_key is 0 until the first update.

Test Plan:
- Key update 0x1918111009080100, then req0 sends 0x65656877 tag 3 → key_busy clears after drain+KEYLOAD+KEY_SETTLE; rsp_valid exactly LATENCY+2 cycles after accept; rsp_data 0xc69be9bb, rsp_src 0, rsp_tag 3.
- Both requesters continuously valid for 8 cycles → grants alternate 0,1,0,1…; 8 responses in the same order on consecutive cycles; inflight peaks, then returns to 0.
- key_update while 5 blocks are in flight → readys drop the next cycle; all 5 responses are computed with the old key; core_key changes only after inflight==0; issuing resumes KEY_SETTLE cycles later.
- Two key_update pulses, one in DRAIN and one in SETTLE → only the second key is used by subsequent blocks; no block is issued between them.
- rst asserted with 10 blocks in flight → the following cycle all outputs are 0; no rsp_valid within LATENCY+4 cycles after reset.
- Accept and response in the same cycle with inflight=7 → inflight stays 7.
